// File: rtl/pipe_hazard_ctrl.sv
// Hazard/flush controller for the 5-stage RV32 pipeline: per-stage stall/bubble with
// prioritised mem-wait, MDU, branch-flush and load-use handling. Perf counters: HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_AW          = 5,
  parameter int unsigned LOAD_USE_CYCLES = 1,
  parameter int unsigned PERF_W          = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              execute_i_need_jump,
  input  logic [REG_AW-1:0] decode_i_rs1,
  input  logic [REG_AW-1:0] decode_i_rs2,
  input  logic              decode_i_rs1_ren,
  input  logic              decode_i_rs2_ren,
  input  logic [REG_AW-1:0] regE_i_rd,
  input  logic              regE_i_is_load,
  input  logic              execute_i_mdu_start,
  input  logic              execute_i_mdu_done,
  input  logic              regM_i_mem_req,
  input  logic              dmem_i_ready,
  output logic              ctrl_o_regF_stall,
  output logic              ctrl_o_regD_stall,
  output logic              ctrl_o_regE_stall,
  output logic              ctrl_o_regM_stall,
  output logic              ctrl_o_regW_stall,
  output logic              ctrl_o_regF_bubble,
  output logic              ctrl_o_regD_bubble,
  output logic              ctrl_o_regE_bubble,
  output logic              ctrl_o_regM_bubble,
  output logic              ctrl_o_regW_bubble,
  output logic              ctrl_o_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] ctrl_o_stall_cycles,
  output logic [PERF_W-1:0] ctrl_o_flush_cnt,
  output logic [PERF_W-1:0] ctrl_o_lu_cnt
`endif
);

  localparam int unsigned LuW = $clog2(LOAD_USE_CYCLES) + 1;
  localparam logic [LuW-1:0] LuLoad = LuW'(LOAD_USE_CYCLES - 1);

  if (LOAD_USE_CYCLES < 1 || LOAD_USE_CYCLES > 4 || PERF_W < 1) begin : g_bad_param
    $error("pipe_hazard_ctrl: LOAD_USE_CYCLES must be 1..4 and PERF_W at least 1");
  end

  typedef enum logic {
    IDLE     = 1'b0,
    MDU_BUSY = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [LuW-1:0] lu_cnt_q, lu_cnt_d;

  logic lu_hit, mem_wait, mdu_busy, lu_active;
  logic sel_mem, sel_mdu, sel_jmp, sel_lu, lu_load;

  // Raw hazard terms; x0 never creates a dependency.
  assign lu_hit = regE_i_is_load & (regE_i_rd != '0) &
                  ((decode_i_rs1_ren & (regE_i_rd == decode_i_rs1)) |
                   (decode_i_rs2_ren & (regE_i_rd == decode_i_rs2)));
  assign mem_wait  = regM_i_mem_req & ~dmem_i_ready;
  assign mdu_busy  = ((state_q == IDLE) & execute_i_mdu_start & ~execute_i_mdu_done) |
                     ((state_q == MDU_BUSY) & ~execute_i_mdu_done);
  assign lu_active = lu_hit | (lu_cnt_q != '0);

  // One-hot priority select; everything is forced idle while reset is held.
  assign sel_mem = rst_n & mem_wait;
  assign sel_mdu = rst_n & ~mem_wait & mdu_busy;
  assign sel_jmp = rst_n & ~mem_wait & ~mdu_busy & execute_i_need_jump;
  assign sel_lu  = rst_n & ~mem_wait & ~mdu_busy & ~execute_i_need_jump & lu_active;
  assign lu_load = sel_lu & (lu_cnt_q == '0) & lu_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lu_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
    end
  end

  // MDU FSM and load-use penalty counter; both hold while the memory stage waits.
  always_comb begin
    state_d  = state_q;
    lu_cnt_d = lu_cnt_q;
    case (state_q)
      IDLE: begin
        if (execute_i_mdu_start & ~execute_i_mdu_done & ~mem_wait) state_d = MDU_BUSY;
      end
      MDU_BUSY: begin
        if (execute_i_mdu_done & ~mem_wait) state_d = IDLE;
      end
    endcase
    if (sel_jmp) begin
      lu_cnt_d = '0;
    end else if (sel_lu) begin
      if (lu_cnt_q != '0) lu_cnt_d = lu_cnt_q - LuW'(1);
      else if (lu_hit)    lu_cnt_d = LuLoad;
    end
  end

  always_comb begin
    ctrl_o_regF_stall  = 1'b0;
    ctrl_o_regD_stall  = 1'b0;
    ctrl_o_regE_stall  = 1'b0;
    ctrl_o_regM_stall  = 1'b0;
    ctrl_o_regW_stall  = 1'b0;
    ctrl_o_regF_bubble = 1'b0;
    ctrl_o_regD_bubble = 1'b0;
    ctrl_o_regE_bubble = 1'b0;
    ctrl_o_regM_bubble = 1'b0;
    ctrl_o_regW_bubble = 1'b0;
    if (sel_mem) begin
      ctrl_o_regF_stall  = 1'b1;
      ctrl_o_regD_stall  = 1'b1;
      ctrl_o_regE_stall  = 1'b1;
      ctrl_o_regM_stall  = 1'b1;
      ctrl_o_regW_bubble = 1'b1;
    end else if (sel_mdu) begin
      ctrl_o_regF_stall  = 1'b1;
      ctrl_o_regD_stall  = 1'b1;
      ctrl_o_regE_stall  = 1'b1;
      ctrl_o_regM_bubble = 1'b1;
    end else if (sel_jmp) begin
      ctrl_o_regD_bubble = 1'b1;
      ctrl_o_regE_bubble = 1'b1;
    end else if (sel_lu) begin
      ctrl_o_regF_stall  = 1'b1;
      ctrl_o_regD_stall  = 1'b1;
      ctrl_o_regE_bubble = 1'b1;
    end
    ctrl_o_busy = ctrl_o_regF_stall | ctrl_o_regD_stall | ctrl_o_regE_stall |
                  ctrl_o_regM_stall | ctrl_o_regW_stall;
  end

`ifdef HAZARD_PERF_CNT_EN
  // Free-running event counters, wrapping naturally at the counter width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_o_stall_cycles <= '0;
      ctrl_o_flush_cnt    <= '0;
      ctrl_o_lu_cnt       <= '0;
    end else begin
      if (ctrl_o_busy) ctrl_o_stall_cycles <= ctrl_o_stall_cycles + PERF_W'(1);
      if (sel_jmp)     ctrl_o_flush_cnt    <= ctrl_o_flush_cnt + PERF_W'(1);
      if (lu_load)     ctrl_o_lu_cnt       <= ctrl_o_lu_cnt + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (1- and 3-cycle load-use penalty) on shared inputs,
// expected stall/bubble vectors pushed to a scoreboard queue and popped at the negedge.
module tb_pipe_hazard_ctrl;

  localparam int unsigned AW = 5;
  localparam int unsigned PW_A = 32;
  localparam int unsigned PW_B = 3;

  // {F,D,E,M,W stall, F,D,E,M,W bubble, busy}
  localparam logic [10:0] NONE = 11'b00000_00000_0;
  localparam logic [10:0] LU   = 11'b11000_00100_1;
  localparam logic [10:0] MDU  = 11'b11100_00010_1;
  localparam logic [10:0] MEM  = 11'b11110_00001_1;
  localparam logic [10:0] JMP  = 11'b00000_01100_0;

  logic clk = 1'b0;
  logic rst_n;
  logic need_jump, rs1_ren, rs2_ren, is_load, mdu_start, mdu_done, mem_req, dmem_ready;
  logic [AW-1:0] rs1, rs2, rd;

  logic [10:0] obs_a, obs_b;
  logic a_fs, a_ds, a_es, a_ms, a_ws, a_fb, a_db, a_eb, a_mb, a_wb, a_busy;
  logic b_fs, b_ds, b_es, b_ms, b_ws, b_fb, b_db, b_eb, b_mb, b_wb, b_busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [PW_A-1:0] a_stall_cyc, a_flush, a_lu;
  logic [PW_B-1:0] b_stall_cyc, b_flush, b_lu;
  int t_stall_a, t_flush_a, t_lu_a, t_stall_b, t_flush_b, t_lu_b;
  bit prev_b_lu;
`endif

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    string       tag;
    logic [10:0] exp;
  } sb_t;
  sb_t sbq[$];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(AW), .LOAD_USE_CYCLES(1), .PERF_W(PW_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .execute_i_need_jump(need_jump),
    .decode_i_rs1(rs1), .decode_i_rs2(rs2), .decode_i_rs1_ren(rs1_ren), .decode_i_rs2_ren(rs2_ren),
    .regE_i_rd(rd), .regE_i_is_load(is_load), .execute_i_mdu_start(mdu_start),
    .execute_i_mdu_done(mdu_done), .regM_i_mem_req(mem_req), .dmem_i_ready(dmem_ready),
    .ctrl_o_regF_stall(a_fs), .ctrl_o_regD_stall(a_ds), .ctrl_o_regE_stall(a_es),
    .ctrl_o_regM_stall(a_ms), .ctrl_o_regW_stall(a_ws),
    .ctrl_o_regF_bubble(a_fb), .ctrl_o_regD_bubble(a_db), .ctrl_o_regE_bubble(a_eb),
    .ctrl_o_regM_bubble(a_mb), .ctrl_o_regW_bubble(a_wb), .ctrl_o_busy(a_busy)
`ifdef HAZARD_PERF_CNT_EN
    , .ctrl_o_stall_cycles(a_stall_cyc), .ctrl_o_flush_cnt(a_flush), .ctrl_o_lu_cnt(a_lu)
`endif
  );

  pipe_hazard_ctrl #(.REG_AW(AW), .LOAD_USE_CYCLES(3), .PERF_W(PW_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .execute_i_need_jump(need_jump),
    .decode_i_rs1(rs1), .decode_i_rs2(rs2), .decode_i_rs1_ren(rs1_ren), .decode_i_rs2_ren(rs2_ren),
    .regE_i_rd(rd), .regE_i_is_load(is_load), .execute_i_mdu_start(mdu_start),
    .execute_i_mdu_done(mdu_done), .regM_i_mem_req(mem_req), .dmem_i_ready(dmem_ready),
    .ctrl_o_regF_stall(b_fs), .ctrl_o_regD_stall(b_ds), .ctrl_o_regE_stall(b_es),
    .ctrl_o_regM_stall(b_ms), .ctrl_o_regW_stall(b_ws),
    .ctrl_o_regF_bubble(b_fb), .ctrl_o_regD_bubble(b_db), .ctrl_o_regE_bubble(b_eb),
    .ctrl_o_regM_bubble(b_mb), .ctrl_o_regW_bubble(b_wb), .ctrl_o_busy(b_busy)
`ifdef HAZARD_PERF_CNT_EN
    , .ctrl_o_stall_cycles(b_stall_cyc), .ctrl_o_flush_cnt(b_flush), .ctrl_o_lu_cnt(b_lu)
`endif
  );

  assign obs_a = {a_fs, a_ds, a_es, a_ms, a_ws, a_fb, a_db, a_eb, a_mb, a_wb, a_busy};
  assign obs_b = {b_fs, b_ds, b_es, b_ms, b_ws, b_fb, b_db, b_eb, b_mb, b_wb, b_busy};

  task automatic clr();
    need_jump = 1'b0; rs1 = '0; rs2 = '0; rs1_ren = 1'b0; rs2_ren = 1'b0;
    rd = '0; is_load = 1'b0; mdu_start = 1'b0; mdu_done = 1'b0;
    mem_req = 1'b0; dmem_ready = 1'b1;
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Push expectations, compare at negedge, then advance one clock.
  task automatic step(input string tag, input logic [10:0] ea, input logic [10:0] eb);
    sb_t e;
    sbq.push_back('{tag: {tag, "/a"}, exp: ea});
    sbq.push_back('{tag: {tag, "/b"}, exp: eb});
    @(negedge clk);
    e = sbq.pop_front();
    n_chk++;
    assert (obs_a === e.exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", e.tag, obs_a, e.exp);
    end
    e = sbq.pop_front();
    n_chk++;
    assert (obs_b === e.exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", e.tag, obs_b, e.exp);
    end
    @(posedge clk);
    #1;
`ifdef HAZARD_PERF_CNT_EN
    if (rst_n === 1'b0) begin
      t_stall_a = 0; t_flush_a = 0; t_lu_a = 0;
      t_stall_b = 0; t_flush_b = 0; t_lu_b = 0;
      prev_b_lu = 1'b0;
    end else begin
      t_stall_a += int'(ea[0]);
      t_flush_a += int'(ea == JMP);
      t_lu_a    += int'(ea == LU);
      t_stall_b += int'(eb[0]);
      t_flush_b += int'(eb == JMP);
      t_lu_b    += int'((eb == LU) && !prev_b_lu);
      prev_b_lu = (eb == LU);
    end
    chk_cnt({tag, "/a_stall_cycles"}, a_stall_cyc, 32'(t_stall_a));
    chk_cnt({tag, "/a_flush_cnt"}, a_flush, 32'(t_flush_a));
    chk_cnt({tag, "/a_lu_cnt"}, a_lu, 32'(t_lu_a));
    chk_cnt({tag, "/b_stall_cycles"}, 32'(b_stall_cyc), 32'(t_stall_b % 8));
    chk_cnt({tag, "/b_flush_cnt"}, 32'(b_flush), 32'(t_flush_b % 8));
    chk_cnt({tag, "/b_lu_cnt"}, 32'(b_lu), 32'(t_lu_b % 8));
`endif
  endtask

  initial begin
`ifdef HAZARD_PERF_CNT_EN
    t_stall_a = 0; t_flush_a = 0; t_lu_a = 0;
    t_stall_b = 0; t_flush_b = 0; t_lu_b = 0;
    prev_b_lu = 1'b0;
`endif
    clr();
    rst_n = 1'b0;
    is_load = 1'b1; rd = 5'd5; rs1 = 5'd5; rs1_ren = 1'b1;
    step("reset_hold", NONE, NONE);
    clr();
    rst_n = 1'b1;
    step("idle", NONE, NONE);

    // Load x5 followed by a reader of x5.
    is_load = 1'b1; rd = 5'd5; rs1 = 5'd5; rs1_ren = 1'b1;
    step("lu_c1", LU, LU);
    clr();
    step("lu_c2", NONE, LU);
    step("lu_c3", NONE, LU);
    step("lu_c4", NONE, NONE);

    is_load = 1'b1; rd = 5'd0; rs1 = 5'd0; rs1_ren = 1'b1;
    step("lu_x0", NONE, NONE);
    is_load = 1'b1; rd = 5'd5; rs1 = 5'd5; rs1_ren = 1'b0; rs2 = 5'd7; rs2_ren = 1'b1;
    step("lu_noren", NONE, NONE);

    // rs2 hazard, then a taken branch in the second penalty cycle.
    is_load = 1'b1; rd = 5'd9; rs2 = 5'd9; rs2_ren = 1'b1;
    step("lu_rs2", LU, LU);
    clr();
    need_jump = 1'b1;
    step("lu_jump", JMP, JMP);
    clr();
    step("lu_after_jump", NONE, NONE);

    is_load = 1'b1; rd = 5'd3; rs1 = 5'd3; rs1_ren = 1'b1; need_jump = 1'b1;
    step("lu_with_jump", JMP, JMP);
    clr();
    step("lu_dropped", NONE, NONE);

    is_load = 1'b1; rd = 5'd4; rs1 = 5'd4; rs1_ren = 1'b1; mem_req = 1'b1; dmem_ready = 1'b0;
    step("lu_under_mem", MEM, MEM);
    clr();
    step("lu_not_loaded", NONE, NONE);

    // Multi-cycle MDU: done four cycles after start.
    mdu_start = 1'b1;
    for (int i = 0; i < 4; i++) step($sformatf("mdu_busy%0d", i), MDU, MDU);
    mdu_done = 1'b1;
    step("mdu_done", NONE, NONE);
    clr();
    step("mdu_idle", NONE, NONE);
    mdu_start = 1'b1; mdu_done = 1'b1;
    step("mdu_same_cycle", NONE, NONE);
    clr();
    step("mdu_same_after", NONE, NONE);

    // FSM holds while memory waits, even if done arrives.
    mdu_start = 1'b1;
    step("mdu_frz_start", MDU, MDU);
    mem_req = 1'b1; dmem_ready = 1'b0; mdu_done = 1'b1;
    step("mdu_frz_mem", MEM, MEM);
    mem_req = 1'b0; dmem_ready = 1'b1; mdu_done = 1'b0;
    step("mdu_frz_held", MDU, MDU);
    mdu_done = 1'b1;
    step("mdu_frz_done", NONE, NONE);
    clr();
    step("mdu_frz_idle", NONE, NONE);

    // Memory wait defers a pending branch flush.
    need_jump = 1'b1; mem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step($sformatf("mem_wait%0d", i), MEM, MEM);
    dmem_ready = 1'b1;
    step("mem_ready_jump", JMP, JMP);
    clr();
    step("mem_after", NONE, NONE);

    // Reset in the second MDU_BUSY cycle.
    mdu_start = 1'b1;
    step("rst_mdu_start", MDU, MDU);
    step("rst_mdu_busy1", MDU, MDU);
    rst_n = 1'b0;
    step("rst_mdu_abort", NONE, NONE);
    rst_n = 1'b1;
    mdu_start = 1'b0;
    step("rst_mdu_idle", NONE, NONE);
    step("rst_mdu_idle2", NONE, NONE);

    // Reset in the middle of a load-use penalty.
    is_load = 1'b1; rd = 5'd6; rs1 = 5'd6; rs1_ren = 1'b1;
    step("rst_lu_start", LU, LU);
    clr();
    rst_n = 1'b0;
    step("rst_lu_abort", NONE, NONE);
    rst_n = 1'b1;
    step("rst_lu_idle", NONE, NONE);

    // Extra traffic to push the narrow perf counters through a wrap.
    for (int i = 0; i < 3; i++) begin
      need_jump = 1'b1;
      step($sformatf("wrap_jump%0d", i), JMP, JMP);
      clr();
      mem_req = 1'b1; dmem_ready = 1'b0;
      step($sformatf("wrap_mem%0d", i), MEM, MEM);
      step($sformatf("wrap_mem%0db", i), MEM, MEM);
      clr();
      step($sformatf("wrap_idle%0d", i), NONE, NONE);
    end

    n_chk++;
    assert (sbq.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sbq.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
